// File: rtl/sub_shift_serial.sv
// SubBytes (+ ShiftRows when SUB_SHIFT_ROWS_EN is defined) over LANES registered S-boxes per cycle.
// Latency: 16/LANES + 2 cycles from the accepting edge to out_valid.
// Backpressure: one state in flight; in_ready low until the result is taken, result held while out_ready is low.
module sub_shift_serial #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [127:0]  hold_q;
    logic [CW-1:0] cnt_q;
    logic          iv_q;
    logic [CW-1:0] kd_q;
    logic [7:0]    out_b [16];
    logic [127:0]  beat_dat;
    logic [7:0]    s_out [LANES];
    logic [3:0]    src [LANES];
    logic [3:0]    dst [LANES];
    logic          in_fire;
    logic          last_beat;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign in_fire   = in_valid & in_ready;
    assign last_beat = (cnt_q == CW'(N - 1));

    // Current beat's bytes moved to the top of the word so lane j reads a fixed slice.
    assign beat_dat = hold_q << (8 * LANES * int'(cnt_q));

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        S u_s (
            .clk  (clk),
            .din  (beat_dat[127-8*j -: 8]),
            .dout (s_out[j])
        );
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            src[j] = 4'(int'(kd_q) * LANES + j);
`ifdef SUB_SHIFT_ROWS_EN
            // Byte (r,c) lands in column (c - r) mod 4 of the same row.
            dst[j] = {src[j][3:2] - src[j][1:0], src[j][1:0]};
`else
            dst[j] = src[j];
`endif
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 16; k++) begin
            out_data[127-8*k -: 8] = out_b[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = ISSUE;
            ISSUE:   if (last_beat) state_d = DRAIN;
            // Leave only once the final beat has been written into out_b.
            DRAIN:   if (!iv_q)     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            iv_q    <= 1'b0;
            kd_q    <= '0;
            for (int k = 0; k < 16; k++) begin
                out_b[k] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            iv_q    <= (state_q == ISSUE);
            kd_q    <= cnt_q;
            if (in_fire) begin
                hold_q <= in_data;
                cnt_q  <= '0;
            end else if (state_q == ISSUE) begin
                cnt_q  <= cnt_q + CW'(1);
            end
            if (iv_q) begin
                for (int j = 0; j < LANES; j++) begin
                    out_b[dst[j]] <= s_out[j];
                end
            end
        end
    end
endmodule

// Registered AES S-box: GF(2^8) inverse by square-and-multiply, then the affine map.
// Latency: 1 cycle. No reset; consumers qualify the output themselves.
module S (
    input  logic       clk,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        // a^254 = a^2 * a^4 * ... * a^128, which also maps 0 to 0.
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_ff @(posedge clk) begin
        dout <= sbox(din);
    end
endmodule

// File: tb/tb_sub_shift_serial.sv
// Bench for sub_shift_serial with LANES = 4, 1 and 16 instances against a table-driven reference.
module tb_sub_shift_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [2:0]        in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0][127:0] in_data, out_data;

    int tests = 0;
    int fails = 0;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    sub_shift_serial #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]));
    sub_shift_serial #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]));
    sub_shift_serial #(.LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2]));

    function automatic int exp_lat(input int d);
        int lanes;
        lanes = (d == 0) ? 4 : (d == 1) ? 1 : 16;
        return 16 / lanes + 2;
    endfunction

    // Reference: out s'[r,c] = S(s[r,(c+r) mod 4]) with ShiftRows, S(s[r,c]) without.
    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   a [4][4];
        logic [127:0] o;
        int           sc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[r][c] = s[127-8*(r+4*c) -: 8];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
`ifdef SUB_SHIFT_ROWS_EN
                sc = (c + r) % 4;
`else
                sc = c;
`endif
                o[127-8*(r+4*c) -: 8] = SBOX[a[r][sc]];
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers din, counts cycles from the accepting edge to out_valid, then takes the result.
    task automatic transact(input int d, input logic [127:0] din, input bit rdy_early,
                            output logic [127:0] dout, output int lat);
        int guard;
        out_ready[d] = rdy_early;
        in_data[d]   = din;
        in_valid[d]  = 1'b1;
        guard = 0;
        while (in_ready[d] !== 1'b1 && guard < 200) begin
            step();
            guard++;
        end
        step();
        in_valid[d] = 1'b0;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        dout = out_data[d];
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        in_data = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_ctrl dut%0d: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                         d, in_ready[d], out_valid[d], busy[d]);
            end
            tests++;
            if (out_data[d] !== 128'h0) begin
                fails++;
                $display("FAIL reset_data dut%0d: got %h want 0", d, out_data[d]);
            end
        end
    endtask

    task automatic test_fips();
        logic [127:0] din, dout, want;
        int lat;
        din = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef SUB_SHIFT_ROWS_EN
        want = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
        want = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
        transact(0, din, 1'b0, dout, lat);
        tests++;
        if (lat !== 6) begin
            fails++;
            $display("FAIL fips_latency: got %0d want 6", lat);
        end
        tests++;
        if (dout !== want) begin
            fails++;
            $display("FAIL fips_data: got %h want %h", dout, want);
        end
        tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL fips_after_handshake: out_valid=%b in_ready=%b want 0 1",
                     out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_constants();
        logic [127:0] dout;
        int lat;
        transact(1, 128'h0, 1'b0, dout, lat);
        tests++;
        if (dout !== {16{8'h63}} || lat !== 18) begin
            fails++;
            $display("FAIL zero_lanes1: data %h lat %0d, want all 63 lat 18", dout, lat);
        end
        transact(2, 128'h0, 1'b0, dout, lat);
        tests++;
        if (dout !== {16{8'h63}} || lat !== 3) begin
            fails++;
            $display("FAIL zero_lanes16: data %h lat %0d, want all 63 lat 3", dout, lat);
        end
        transact(0, {16{8'h53}}, 1'b0, dout, lat);
        tests++;
        if (dout !== {16{8'hed}}) begin
            fails++;
            $display("FAIL all53: got %h want all ed", dout);
        end
    endtask

    task automatic test_random();
        logic [127:0] din, dout;
        int d, lat;
        for (int i = 0; i < 24; i++) begin
            d   = $urandom_range(0, 2);
            din = rand128();
            transact(d, din, 1'($urandom_range(0, 1)), dout, lat);
            tests++;
            if (dout !== model(din) || lat !== exp_lat(d)) begin
                fails++;
                $display("FAIL random_%0d dut%0d: data %h lat %0d, want %h lat %0d",
                         i, d, dout, lat, model(din), exp_lat(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        int guard, lat;
        bit bad;
        a = rand128();
        b = rand128();
        out_ready[0] = 1'b0;
        in_data[0]   = a;
        in_valid[0]  = 1'b1;
        step();
        in_data[0] = b;
        guard = 0;
        while (out_valid[0] !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_data[0] !== model(a) || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL backpressure_hold: data %h in_ready %b out_valid %b, want %h 0 1",
                     out_data[0], in_ready[0], out_valid[0], model(a));
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1",
                     out_valid[0], in_ready[0]);
        end
        step();
        in_valid[0] = 1'b0;
        tests++;
        if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL pending_accept: in_ready=%b busy=%b want 0 1", in_ready[0], busy[0]);
        end
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        tests++;
        if (out_data[0] !== model(b) || lat !== 6) begin
            fails++;
            $display("FAIL pending_result: data %h lat %0d, want %h lat 6", out_data[0], lat, model(b));
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] din, dout;
        int lat, seen;
        in_data[0]  = rand128();
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready[0], out_valid[0], busy[0]);
        end
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== 128'h0) begin
            fails++;
            $display("FAIL reset_mid_release: in_ready=%b out_valid=%b data %h want 1 0 0",
                     in_ready[0], out_valid[0], out_data[0]);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid[0] === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_output: out_valid seen %0d cycles, want 0", seen);
        end
        din = rand128();
        transact(0, din, 1'b0, dout, lat);
        tests++;
        if (dout !== model(din) || lat !== 6) begin
            fails++;
            $display("FAIL reset_mid_next: data %h lat %0d, want %h lat 6", dout, lat, model(din));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fips();
        test_constants();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
